// File: rtl/avalon_mem_pkg.sv
// Shared types and constants for the start/done to Avalon-MM responder.
package avalon_mem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT_RD = 2'd2,
        DONE    = 2'd3
    } avm_state_t;

    localparam int DEFAULT_TIMEOUT = 255;

    // Byte-enable width for a data bus of data_w bits.
    function automatic int be_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/avalon_mem_responder_if.sv
// Avalon-MM master-side signal bundle; master modport is the responder, slave is the interconnect.
interface avalon_mem_responder_if
    import avalon_mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int BE_W   = be_width(DATA_W)
) ();

    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_write;
    logic [DATA_W-1:0] avm_writedata;
    logic [BE_W-1:0]   avm_byteenable;
    logic              avm_waitrequest;
    logic [DATA_W-1:0] avm_readdata;
    logic              avm_readdatavalid;

    modport master (
        output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
        input  avm_waitrequest, avm_readdata, avm_readdatavalid
    );

    modport slave (
        input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
        output avm_waitrequest, avm_readdata, avm_readdatavalid
    );

endinterface

// File: rtl/avm_timeout_ctr.sv
// Bus-wait watchdog: counts busy cycles since clear and flags the LIMIT-th one.
module avm_timeout_ctr
    import avalon_mem_pkg::*;
#(
    parameter int LIMIT = DEFAULT_TIMEOUT
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    // Combinational so the FSM can leave on the LIMIT-th busy cycle itself.
    assign expired = en && (count == CW'(LIMIT - 1));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/avalon_mem_responder.sv
// Turns a start/done access request into one Avalon-MM read or write and reports completion.
// Optional bus-wait abort is compiled in with `define AVM_TIMEOUT_EN.
module avalon_mem_responder
    import avalon_mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 start,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [DATA_W-1:0]    wdata,
    input  logic [DATA_W/8-1:0]  be,
    output logic                 done,
    output logic [DATA_W-1:0]    rdata,
    output logic                 error,
    avalon_mem_responder_if.master avm
);

    localparam int BE_W = be_width(DATA_W);

    avm_state_t        state, state_nxt;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [BE_W-1:0]   be_q;
    logic [DATA_W-1:0] rdata_q;
    logic              error_q;
    logic              capture;
    logic              abort;
    logic              timeout_hit;
    logic              accept;

    assign accept = (state == IDLE) && start;

`ifdef AVM_TIMEOUT_EN
    avm_timeout_ctr #(.LIMIT(TIMEOUT)) u_timeout_ctr (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .clr     (accept),
        .en      ((state == REQ) || (state == WAIT_RD)),
        .expired (timeout_hit)
    );
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT;
    assign timeout_hit    = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        abort     = 1'b0;
        unique case (state)
            IDLE: if (start) state_nxt = REQ;
            REQ: begin
                // Data or write acceptance beats the timeout when both land in the same cycle.
                if (!avm.avm_waitrequest && (we_q || avm.avm_readdatavalid)) begin
                    capture   = !we_q;
                    state_nxt = DONE;
                end else if (timeout_hit) begin
                    abort     = 1'b1;
                    state_nxt = DONE;
                end else if (!avm.avm_waitrequest) begin
                    state_nxt = WAIT_RD;
                end
            end
            WAIT_RD: begin
                if (avm.avm_readdatavalid) begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end else if (timeout_hit) begin
                    abort     = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: request registers drive the bus directly, so they are reset to give a defined idle bus.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else if (accept) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
            be_q    <= be;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            error_q <= abort;
            if (capture) begin
                rdata_q <= avm.avm_readdata;
            end else if (abort) begin
                rdata_q <= '0;
            end
        end
    end

    assign done  = (state == DONE);
    assign rdata = rdata_q;
    assign error = error_q;

    assign avm.avm_read       = (state == REQ) && !we_q;
    assign avm.avm_write      = (state == REQ) && we_q;
    assign avm.avm_address    = addr_q;
    assign avm.avm_writedata  = wdata_q;
    assign avm.avm_byteenable = be_q;

endmodule
